// File: rtl/lstm_l1_fwd_ctrl.sv
// Layer-1 LSTM forward-pass sequencer.
// Walks every (timestep t, cell j) pair. Each cell takes N+3 cycles: one clear
// cycle, N multiply-accumulate cycles, one pipeline-drain cycle and one
// write-back cycle.
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   start          begin a full forward pass (honoured only while idle)
//   busy, done     pass in progress / one-cycle end-of-pass pulse
//   acc_rst        datapath accumulator clear
//   acc_x_1/acc_h_1  x-MAC / h-MAC accumulate enables
//   addr_x1, rd_addr_w_1, rd_addr_u_1, rd_addr_h1  operand read addresses
//   rd_addr_b_1, rd_addr_c1                        bias / previous-state read addresses
//   wr_h1, wr_c1, wr_addr_h1, wr_addr_c1           h / state write-back
//   first_t        high while t==0 (previous state treated as zero)
module lstm_l1_fwd_ctrl #(
    parameter int unsigned TIMESTEP    = 7,
    parameter int unsigned LAYR1_INPUT = 53,
    parameter int unsigned LAYR1_CELL  = 53,
    parameter int unsigned AW          = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          acc_rst,
    output logic          acc_x_1,
    output logic          acc_h_1,
    output logic [AW-1:0] addr_x1,
    output logic [AW-1:0] rd_addr_w_1,
    output logic [AW-1:0] rd_addr_u_1,
    output logic [AW-1:0] rd_addr_h1,
    output logic [AW-1:0] rd_addr_b_1,
    output logic [AW-1:0] rd_addr_c1,
    output logic          wr_h1,
    output logic          wr_c1,
    output logic [AW-1:0] wr_addr_h1,
    output logic [AW-1:0] wr_addr_c1,
    output logic          first_t
);

    localparam int unsigned N  = (LAYR1_INPUT > LAYR1_CELL) ? LAYR1_INPUT : LAYR1_CELL;
    localparam int unsigned KW = $clog2(N + 1);
    localparam int unsigned TW = $clog2(TIMESTEP + 1);
    localparam int unsigned JW = $clog2(LAYR1_CELL + 1);

    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [KW-1:0] K_IN   = KW'(LAYR1_INPUT);
    localparam logic [KW-1:0] K_CELL = KW'(LAYR1_CELL);
    localparam logic [JW-1:0] J_LAST = JW'(LAYR1_CELL - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMESTEP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_ACC,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] t, t_nxt, t_prev;
    logic [JW-1:0] j, j_nxt;
    logic [KW-1:0] k, k_nxt;

    logic          busy_d, done_d, acc_rst_d, acc_x_d, acc_h_d, wr_d, first_t_d;
    logic [AW-1:0] addr_x_d, addr_w_d, addr_u_d, addr_h_d, addr_b_d, addr_c_d, wr_addr_d;

    // Next state/counters, then output decode from the next values so that
    // every registered output lines up with the state it describes.
    always_comb begin
        state_nxt = state;
        t_nxt     = t;
        j_nxt     = j;
        k_nxt     = k;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        acc_rst_d = 1'b0;
        acc_x_d   = 1'b0;
        acc_h_d   = 1'b0;
        wr_d      = 1'b0;
        first_t_d = 1'b0;
        addr_x_d  = '0;
        addr_w_d  = '0;
        addr_u_d  = '0;
        addr_h_d  = '0;
        addr_b_d  = '0;
        addr_c_d  = '0;
        wr_addr_d = '0;
        t_prev    = '0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_CLR;
                    t_nxt     = '0;
                    j_nxt     = '0;
                    k_nxt     = '0;
                end
            end
            S_CLR: begin
                k_nxt     = '0;
                state_nxt = S_ACC;
            end
            S_ACC: begin
                if (k == K_LAST) begin
                    state_nxt = S_WAIT;
                end else begin
                    k_nxt = k + KW'(1);
                end
            end
            S_WAIT: state_nxt = S_WRITE;
            S_WRITE: begin
                k_nxt = '0;
                if (j < J_LAST) begin
                    j_nxt     = j + JW'(1);
                    state_nxt = S_CLR;
                end else if (t < T_LAST) begin
                    j_nxt     = '0;
                    t_nxt     = t + TW'(1);
                    state_nxt = S_CLR;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        t_prev    = t_nxt - TW'(1);
        busy_d    = (state_nxt == S_CLR) || (state_nxt == S_ACC) ||
                    (state_nxt == S_WAIT) || (state_nxt == S_WRITE);
        done_d    = (state_nxt == S_DONE);
        acc_rst_d = (state_nxt == S_CLR);
        wr_d      = (state_nxt == S_WRITE);
        first_t_d = busy_d && (t_nxt == '0);

        if (state_nxt == S_ACC) begin
            acc_x_d  = (k_nxt < K_IN);
            acc_h_d  = (k_nxt < K_CELL) && (t_nxt != '0);
            addr_x_d = AW'(t_nxt) * AW'(LAYR1_INPUT) + AW'(k_nxt);
            addr_w_d = AW'(j_nxt) * AW'(LAYR1_INPUT) + AW'(k_nxt);
            addr_u_d = AW'(j_nxt) * AW'(LAYR1_CELL) + AW'(k_nxt);
            if (t_nxt != '0) begin
                addr_h_d = AW'(t_prev) * AW'(LAYR1_CELL) + AW'(k_nxt);
            end
        end

        if (busy_d) begin
            addr_b_d = AW'(j_nxt);
            if (t_nxt != '0) begin
                addr_c_d = AW'(t_prev) * AW'(LAYR1_CELL) + AW'(j_nxt);
            end
        end

        if (wr_d) begin
            wr_addr_d = AW'(t_nxt) * AW'(LAYR1_CELL) + AW'(j_nxt);
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            t           <= '0;
            j           <= '0;
            k           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            acc_rst     <= 1'b0;
            acc_x_1     <= 1'b0;
            acc_h_1     <= 1'b0;
            addr_x1     <= '0;
            rd_addr_w_1 <= '0;
            rd_addr_u_1 <= '0;
            rd_addr_h1  <= '0;
            rd_addr_b_1 <= '0;
            rd_addr_c1  <= '0;
            wr_h1       <= 1'b0;
            wr_c1       <= 1'b0;
            wr_addr_h1  <= '0;
            wr_addr_c1  <= '0;
            first_t     <= 1'b0;
        end else begin
            state       <= state_nxt;
            t           <= t_nxt;
            j           <= j_nxt;
            k           <= k_nxt;
            busy        <= busy_d;
            done        <= done_d;
            acc_rst     <= acc_rst_d;
            acc_x_1     <= acc_x_d;
            acc_h_1     <= acc_h_d;
            addr_x1     <= addr_x_d;
            rd_addr_w_1 <= addr_w_d;
            rd_addr_u_1 <= addr_u_d;
            rd_addr_h1  <= addr_h_d;
            rd_addr_b_1 <= addr_b_d;
            rd_addr_c1  <= addr_c_d;
            wr_h1       <= wr_d;
            wr_c1       <= wr_d;
            wr_addr_h1  <= wr_addr_d;
            wr_addr_c1  <= wr_addr_d;
            first_t     <= first_t_d;
        end
    end

endmodule

// File: tb/tb_lstm_l1_fwd_ctrl.sv
// Bench for lstm_l1_fwd_ctrl: default-size instance plus a small
// (TIMESTEP=2, LAYR1_INPUT=4, LAYR1_CELL=2) instance.
module tb_lstm_l1_fwd_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        rst, start;
    logic        busy, done, acc_rst, acc_x_1, acc_h_1, wr_h1, wr_c1, first_t;
    logic [11:0] addr_x1, rd_addr_w_1, rd_addr_u_1, rd_addr_h1, rd_addr_b_1, rd_addr_c1;
    logic [11:0] wr_addr_h1, wr_addr_c1;

    lstm_l1_fwd_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .acc_rst(acc_rst), .acc_x_1(acc_x_1), .acc_h_1(acc_h_1),
        .addr_x1(addr_x1), .rd_addr_w_1(rd_addr_w_1), .rd_addr_u_1(rd_addr_u_1),
        .rd_addr_h1(rd_addr_h1), .rd_addr_b_1(rd_addr_b_1), .rd_addr_c1(rd_addr_c1),
        .wr_h1(wr_h1), .wr_c1(wr_c1), .wr_addr_h1(wr_addr_h1), .wr_addr_c1(wr_addr_c1),
        .first_t(first_t)
    );

    // Small instance
    logic        rst_s, start_s;
    logic        busy_s, done_s, acc_rst_s, acc_x_s, acc_h_s, wr_h_s, wr_c_s, first_t_s;
    logic [11:0] ax_s, aw_s, au_s, ah_s, ab_s, ac_s, wah_s, wac_s;

    lstm_l1_fwd_ctrl #(.TIMESTEP(2), .LAYR1_INPUT(4), .LAYR1_CELL(2), .AW(12)) dut_s (
        .clk(clk), .rst(rst_s), .start(start_s), .busy(busy_s), .done(done_s),
        .acc_rst(acc_rst_s), .acc_x_1(acc_x_s), .acc_h_1(acc_h_s),
        .addr_x1(ax_s), .rd_addr_w_1(aw_s), .rd_addr_u_1(au_s),
        .rd_addr_h1(ah_s), .rd_addr_b_1(ab_s), .rd_addr_c1(ac_s),
        .wr_h1(wr_h_s), .wr_c1(wr_c_s), .wr_addr_h1(wah_s), .wr_addr_c1(wac_s),
        .first_t(first_t_s)
    );

    int vectors     = 0;
    int miscompares = 0;
    int busy_cnt    = 0;
    int done_cnt    = 0;

    logic [11:0] sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
        finish_run();
    endtask

    // Wait for n acc_rst pulses (cell starts) on the default instance.
    task automatic wait_clr(input int n, output bit ok);
        int seen = 0;
        ok = 1'b0;
        for (int c = 0; c < 30000; c++) begin
            @(negedge clk);
            if (acc_rst) seen++;
            if (seen == n) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Monitor: pops the expected write address on every write-back.
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (wr_h1) begin
            check("wr_acc_exclusive", 64'({acc_x_1, acc_h_1}), 64'd0);
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_unexpected_write: got addr %0d expected no write", wr_addr_h1);
            end else begin
                logic [11:0] e;
                e = sb.pop_front();
                check("wr_addr_h1", 64'(wr_addr_h1), 64'(e));
                check("wr_c1_addr_c1", 64'({wr_c1, wr_addr_c1}), 64'({1'b1, e}));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int c, p;
        rst = 1'b1; start = 1'b0; rst_s = 1'b1; start_s = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({busy, done, acc_rst, acc_x_1, acc_h_1, wr_h1, wr_c1, first_t,
                                    addr_x1, rd_addr_w_1, rd_addr_u_1, rd_addr_h1}), 64'd0);
        check("reset_addrs", 64'({rd_addr_b_1, rd_addr_c1, wr_addr_h1, wr_addr_c1}), 64'd0);
        rst = 1'b0; rst_s = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 64'({busy, acc_rst}), 64'd0);

        // Pass 1: start held high for the whole pass.
        for (int i = 0; i < 371; i++) sb.push_back(12'(i));
        start = 1'b1;
        @(negedge clk);
        check("clr_cell0", 64'({busy, acc_rst, acc_x_1, first_t, rd_addr_b_1}),
              64'({1'b1, 1'b1, 1'b0, 1'b1, 12'd0}));
        for (int k = 0; k < 53; k++) begin
            @(negedge clk);
            check("acc_cell0", 64'({acc_rst, acc_x_1, acc_h_1, addr_x1, rd_addr_w_1}),
                  64'({1'b0, 1'b1, 1'b0, 12'(k), 12'(k)}));
        end
        @(negedge clk);
        check("wait_cell0", 64'({acc_x_1, acc_h_1, wr_h1, busy}), 64'({3'b000, 1'b1}));
        @(negedge clk);
        check("write_cell0", 64'({wr_h1, wr_addr_h1}), 64'({1'b1, 12'd0}));

        // Cell t=1, j=2 is the 56th cell.
        wait_clr(55, ok);
        if (!ok) timeout("wait_t1_j2");
        check("clr_t1_j2", 64'({rd_addr_b_1, rd_addr_c1, first_t}), 64'({12'd2, 12'd2, 1'b0}));
        for (int k = 0; k < 53; k++) begin
            @(negedge clk);
            check("acc_t1_j2", 64'({acc_x_1, acc_h_1, addr_x1, rd_addr_u_1, rd_addr_h1}),
                  64'({1'b1, 1'b1, 12'(53 + k), 12'(106 + k), 12'(k)}));
        end
        @(negedge clk);
        check("wait_t1_j2", 64'({acc_x_1, acc_h_1}), 64'd0);
        @(negedge clk);
        check("write_t1_j2", 64'({wr_c1, wr_addr_c1}), 64'({1'b1, 12'd55}));

        ok = 1'b0;
        for (int i = 0; i < 25000 && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
        if (!ok) timeout("wait_done_pass1");
        check("done_not_busy", 64'(busy), 64'd0);
        check("busy_cycles", 64'(busy_cnt), 64'd20776);
        @(negedge clk);
        check("idle_after_done", 64'({busy, done}), 64'd0);
        check("writes_drained", 64'(sb.size()), 64'd0);
        @(negedge clk);
        check("restart_held_start", 64'({busy, acc_rst, first_t}), 64'({3'b111}));
        check("done_count", 64'(done_cnt), 64'd1);

        // Pass 2: reset mid-ACC at t=3, j=0.
        start = 1'b0;
        for (int i = 0; i < 159; i++) sb.push_back(12'(i));
        wait_clr(159, ok);
        if (!ok) timeout("wait_t3");
        check("clr_t3", 64'({rd_addr_c1, first_t}), 64'({12'd106, 1'b0}));
        repeat (5) @(negedge clk);
        check("acc_t3", 64'({acc_x_1, addr_x1}), 64'({1'b1, 12'd163}));
        rst = 1'b1;
        @(negedge clk);
        check("midpass_reset_ctl", 64'({busy, done, acc_rst, acc_x_1, acc_h_1, wr_h1, wr_c1, first_t}), 64'd0);
        check("midpass_reset_addr", 64'({addr_x1, rd_addr_w_1, rd_addr_u_1, rd_addr_h1, rd_addr_b_1}), 64'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_after_midreset", 64'({busy, acc_rst}), 64'd0);
        check("no_done_after_reset", 64'(done_cnt), 64'd1);
        check("pass2_writes", 64'(sb.size()), 64'd0);

        // Pass 3 restarts from t=0, j=0.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_clr", 64'({busy, acc_rst, first_t, rd_addr_b_1, rd_addr_c1}),
              64'({3'b111, 12'd0, 12'd0}));
        @(negedge clk);
        check("restart_acc0", 64'({acc_x_1, acc_h_1, addr_x1, rd_addr_w_1}), 64'({2'b10, 24'd0}));
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_overrides_start", 64'({busy, acc_rst}), 64'd0);
        rst = 1'b0; start = 1'b0;

        // Small instance: 4 cells of 7 cycles.
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        for (int cyc = 0; cyc < 28; cyc++) begin
            if (cyc > 0) @(negedge clk);
            c = cyc / 7;
            p = cyc % 7;
            check("small_cycle",
                  64'({busy_s, acc_rst_s, acc_x_s, acc_h_s, wr_h_s}),
                  64'({1'b1, p == 0, (p >= 1 && p <= 4), (c >= 2 && (p == 1 || p == 2)), p == 6}));
            if (p == 6) check("small_wr_addr", 64'(wah_s), 64'(c));
        end
        @(negedge clk);
        check("small_done", 64'({busy_s, done_s}), 64'({1'b0, 1'b1}));

        finish_run();
    end

endmodule

// File: doc/lstm_l1_fwd_ctrl.md
LSTM_L1_FWD_CTRL -- requirements
Module: lstm_l1_fwd_ctrl

Interface
REQ-001 Parameter TIMESTEP, default 7, number of time steps per sequence.
REQ-002 Parameter LAYR1_INPUT, default 53, layer-1 input vector length.
REQ-003 Parameter LAYR1_CELL, default 53, layer-1 cell count.
REQ-004 Parameter AW, default 12, width of every address output.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  begin one full forward pass; sampled only in IDLE.
REQ-008 busy  out  1  high from the cycle after start is accepted until done.
REQ-009 done  out  1  one-cycle pulse at end of pass.
REQ-010 acc_rst  out  1  datapath accumulator clear (drives datapath rst).
REQ-011 acc_x_1, acc_h_1  out  1 each  x-MAC / h-MAC accumulate enables.
REQ-012 addr_x1, rd_addr_w_1, rd_addr_u_1, rd_addr_h1  out  AW each  operand read addresses.
REQ-013 rd_addr_b_1, rd_addr_c1  out  AW each  bias / previous-state read addresses.
REQ-014 wr_h1, wr_c1  out  1 each  h / state write enables.
REQ-015 wr_addr_h1, wr_addr_c1  out  AW each  h / state write addresses.
REQ-016 first_t  out  1  high while t==0 (datapath treats previous c as zero).

Function
REQ-017 The FSM SHALL have states IDLE, CLR, ACC, WAIT, WRITE, DONE; counters t (0..TIMESTEP-1), j (cell, 0..LAYR1_CELL-1), k (0..N-1), N = max(LAYR1_INPUT, LAYR1_CELL).
REQ-018 IDLE: start==1 -> CLR with t=j=0; otherwise stay; start SHALL be ignored in all other states.
REQ-019 CLR lasts 1 cycle, acc_rst=1, k cleared -> ACC.
REQ-020 ACC lasts exactly N cycles; k increments each cycle; -> WAIT after k==N-1.
REQ-021 In ACC acc_x_1 SHALL be 1 iff k<LAYR1_INPUT; acc_h_1 SHALL be 1 iff k<LAYR1_CELL and t>0.
REQ-022 In ACC: addr_x1=t*LAYR1_INPUT+k; rd_addr_w_1=j*LAYR1_INPUT+k; rd_addr_u_1=j*LAYR1_CELL+k; rd_addr_h1=(t-1)*LAYR1_CELL+k when t>0, else 0.
REQ-023 rd_addr_b_1=j in CLR, ACC, WAIT and WRITE; rd_addr_c1=(t-1)*LAYR1_CELL+j when t>0, else 0.
REQ-024 WAIT lasts 1 cycle with both acc enables 0 (pipeline drain) -> WRITE.
REQ-025 WRITE lasts 1 cycle: wr_h1=wr_c1=1, wr_addr_h1=wr_addr_c1=t*LAYR1_CELL+j.
REQ-026 After WRITE: if j<LAYR1_CELL-1, j+=1 -> CLR; else if t<TIMESTEP-1, j=0, t+=1 -> CLR; else -> DONE.
REQ-027 DONE lasts 1 cycle with done=1, busy=0 -> IDLE.
REQ-028 Outside the states named above, every enable SHALL be 0 and every address SHALL be 0.
REQ-029 Cycles per cell SHALL be N+3; total busy cycles SHALL be TIMESTEP*LAYR1_CELL*(N+3).
REQ-030 All address arithmetic SHALL be unsigned, truncated to AW bits; defaults (max 370) SHALL not wrap.
REQ-031 wr_h1 and acc_x_1/acc_h_1 SHALL never be high in the same cycle.

Reset
REQ-032 rst==1 SHALL force IDLE, clear t, j, k, and drive all outputs 0 on the next edge, including mid-pass; rst overrides start in the same cycle.
REQ-033 After rst deasserts, the block SHALL stay in IDLE until a new start.

Verification
REQ-034 Defaults, start pulse -> busy next cycle, acc_rst high 1 cycle, acc_x_1 high 53 cycles with addr_x1 0..52, acc_h_1 low (t=0), first write wr_addr_h1=0.
REQ-035 Defaults, full pass -> exactly 371 wr_h1 pulses at addresses 0..370 in order, done pulses once, busy high 20776 cycles.
REQ-036 t=1, j=2 -> rd_addr_u_1 106..158, rd_addr_h1 0..52, rd_addr_c1=2, wr_addr_c1=55, acc_h_1 high 53 cycles.
REQ-037 LAYR1_INPUT=4, LAYR1_CELL=2, TIMESTEP=2 -> ACC 4 cycles, acc_h_1 high only first 2 at t=1, 28 busy cycles total.
REQ-038 rst asserted during ACC at t=3 -> all outputs 0 next cycle, no done; new start restarts at t=0, j=0.
REQ-039 start held high throughout pass -> ignored while busy; new pass begins one cycle after DONE.
